// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the pipelined CLA adder.
// Signed-overflow output is built only when CLA_OVF_EN is defined.
package cla_pkg;

  localparam int CLA_GROUP_DEFAULT = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: GROUP-bit combinational carry-lookahead adder slice.
// Exports group generate/propagate for lookahead across groups.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] A,
  input  logic [GROUP-1:0] B,
  input  logic             Cin,
  output logic [GROUP-1:0] S,
  output logic             G,
  output logic             P,
  output logic             Cout
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry and G as a flat sum of products of g/p terms.
  always_comb begin
    logic t;
    logic acc;
    t   = 1'b0;
    acc = 1'b0;
    c   = '0;
    G   = 1'b0;
    for (int j = 0; j <= GROUP; j++) begin
      acc = Cin;
      for (int m = 0; m < j; m++) acc = acc & p[m];
      for (int i = 0; i < j; i++) begin
        t = g[i];
        for (int m = i + 1; m < j; m++) t = t & p[m];
        acc = acc | t;
      end
      c[j] = acc;
    end
    acc = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      t = g[i];
      for (int m = i + 1; m < GROUP; m++) t = t & p[m];
      acc = acc | t;
    end
    G = acc;
  end

  assign P    = &p;
  assign S    = p ^ c[GROUP-1:0];
  assign Cout = c[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA, one segment per stage, valid/ready.
// Define CLA_OVF_EN to add the registered signed-overflow port Ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = CLA_GROUP_DEFAULT,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef CLA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;
  localparam int GPS = SEG / GROUP;

  // Skewed operands: stage k keeps only the bits above its segment.
  function automatic int op_off(input int k);
    return k * WIDTH - SEG * k * (k + 1) / 2;
  endfunction

  // Deskewed sums: stage k keeps the low (k+1) segments.
  function automatic int sm_off(input int k);
    return SEG * k * (k + 1) / 2;
  endfunction

  localparam int OPN  = op_off(STAGES - 1);
  localparam int OPW  = (OPN > 0) ? OPN : 1;
  localparam int SMW  = sm_off(STAGES);
  localparam int SOUT = sm_off(STAGES - 1);

  if ((WIDTH % (GROUP * STAGES)) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must divide by GROUP*STAGES");
  end
  if (STAGES < 1 || STAGES > WIDTH / GROUP) begin : g_bad_stages
    $error("cla_pipe_adder: STAGES out of range");
  end

  logic [OPW-1:0]    a_q, a_d;
  logic [OPW-1:0]    b_q, b_d;
  logic [SMW-1:0]    s_q, s_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              adv;

  assign adv       = !v_q[STAGES-1] | Out_ready;
  assign In_ready  = adv;
  assign Out_valid = v_q[STAGES-1];
  assign S         = s_q[SOUT +: WIDTH];
  assign Cout      = c_q[STAGES-1];

`ifdef CLA_OVF_EN
  logic ovf_q, ovf_d;
  assign Ovf = ovf_q;
`endif

  if (OPN == 0) begin : g_no_skew
    assign a_d = '0;
    assign b_d = '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - (k + 1) * SEG;
    localparam int OO = op_off(k);
    localparam int SO = sm_off(k);

    logic [SEG-1:0] sa, sb, ss;
    logic           sci;
    logic [GPS:0]   gc;
    gp_t  [GPS-1:0] gp;
    logic [GPS-1:0] gco;

    if (k == 0) begin : g_head
      assign sa     = A[SEG-1:0];
      assign sb     = B[SEG-1:0];
      assign sci    = Cin;
      assign v_d[k] = In_valid;
      if (RW > 0) begin : g_op
        assign a_d[OO +: RW] = A[WIDTH-1:SEG];
        assign b_d[OO +: RW] = B[WIDTH-1:SEG];
      end
    end else begin : g_body
      localparam int PO = op_off(k - 1);
      localparam int PS = sm_off(k - 1);
      assign sa     = a_q[PO +: SEG];
      assign sb     = b_q[PO +: SEG];
      assign sci    = c_q[k-1];
      assign v_d[k] = v_q[k-1];
      assign s_d[SO +: k*SEG] = s_q[PS +: k*SEG];
      if (RW > 0) begin : g_op
        assign a_d[OO +: RW] = a_q[PO + SEG +: RW];
        assign b_d[OO +: RW] = b_q[PO + SEG +: RW];
      end
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(
        .GROUP(GROUP)
      ) u_grp (
        .A   (sa[j*GROUP +: GROUP]),
        .B   (sb[j*GROUP +: GROUP]),
        .Cin (gc[j]),
        .S   (ss[j*GROUP +: GROUP]),
        .G   (gp[j].g),
        .P   (gp[j].p),
        .Cout(gco[j])
      );
    end

    // Group carry-ins straight from group G/P, no inter-group ripple.
    always_comb begin
      logic t;
      logic acc;
      t  = 1'b0;
      acc = 1'b0;
      gc = '0;
      for (int j = 0; j <= GPS; j++) begin
        acc = sci;
        for (int m = 0; m < j; m++) acc = acc & gp[m].p;
        for (int i = 0; i < j; i++) begin
          t = gp[i].g;
          for (int m = i + 1; m < j; m++) t = t & gp[m].p;
          acc = acc | t;
        end
        gc[j] = acc;
      end
    end

    assign s_d[SO + k*SEG +: SEG] = ss;
    assign c_d[k] = gc[GPS];

`ifdef CLA_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = ss[SEG-1] ^ sa[SEG-1] ^ sb[SEG-1] ^ gc[GPS];
    end
`endif
  end

  // Whole pipeline shifts together on adv; bubbles ride along as v=0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

`ifdef CLA_OVF_EN
  // Overflow travels with the final-stage sum and stalls with it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed vectors plus a queue model of the adder.
// Define CLA_OVF_EN to also exercise the overflow output.
module tb_cla_pipe_adder;

  localparam int W  = 16;
  localparam int ST = 2;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Out_valid;
  logic         Out_ready = 1'b1;
  logic [W-1:0] S;
  logic         Cout;
`ifdef CLA_OVF_EN
  logic         Ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  cla_pipe_adder #(
    .WIDTH (W),
    .GROUP (4),
    .STAGES(ST)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .S        (S),
    .Cout     (Cout)
`ifdef CLA_OVF_EN
    ,
    .Ovf      (Ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cnt;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [W-1:0] a,
                              input logic [W-1:0] b,
                              input logic ci);
    ent_t e;
    logic [W:0] t;
    t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.o   = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    e.cnt = 1;
    return e;
  endfunction

  // Model: each accepted op must appear after ST advancing edges, in order.
  always @(negedge Clk) begin
    logic exp_ov;
    logic madv;
    if (!Rst_n) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (q[0].cnt == ST);
      chk("out_valid", {31'b0, Out_valid}, {31'b0, exp_ov});
      chk("in_ready", {31'b0, In_ready}, {31'b0, !exp_ov || Out_ready});
      if (exp_ov) begin
        chk("sum", {16'b0, S}, {16'b0, q[0].s});
        chk("cout", {31'b0, Cout}, {31'b0, q[0].c});
`ifdef CLA_OVF_EN
        chk("ovf", {31'b0, Ovf}, {31'b0, q[0].o});
`endif
      end
      madv = !exp_ov || Out_ready;
      if (exp_ov && Out_ready) void'(q.pop_front());
      if (madv) begin
        foreach (q[i]) q[i].cnt++;
        if (In_valid) q.push_back(mk(A, B, Cin));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    A = a;
    B = b;
    Cin = ci;
    In_valid = 1'b1;
    step();
    In_valid = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic ci,
                     input logic [W-1:0] es, input logic ec);
    send(a, b, ci);
    chk({nm, "_early"}, {31'b0, Out_valid}, 32'd0);
    step();
    chk({nm, "_valid"}, {31'b0, Out_valid}, 32'd1);
    chk({nm, "_sum"}, {16'b0, S}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, Cout}, {31'b0, ec});
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'b0, Out_valid}, 32'd0);
    chk("rst_sum", {16'b0, S}, 32'd0);
    chk("rst_cout", {31'b0, Cout}, 32'd0);
    repeat (2) step();
    Rst_n = 1'b1;

    pin("t1", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
    step();
    pin("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    pin("wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    pin("seg", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    pin("mix", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    step();

    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        A = 16'(i);
        B = 16'(3 * i);
        Cin = 1'b0;
        In_valid = 1'b1;
      end else begin
        In_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 8) begin
        chk("t3_valid", {31'b0, Out_valid}, 32'd1);
        chk("t3_sum", {16'b0, S}, 32'(4 * (i - 1)));
      end
    end
    chk("t3_gap", {31'b0, Out_valid}, 32'd0);

    Out_ready = 1'b0;
    A = 16'h1234;
    B = 16'h1111;
    Cin = 1'b0;
    In_valid = 1'b1;
    step();
    A = 16'hABCD;
    Cin = 1'b1;
    step();
    In_valid = 1'b0;
    repeat (5) begin
      chk("t4_in_ready", {31'b0, In_ready}, 32'd0);
      chk("t4_hold_v", {31'b0, Out_valid}, 32'd1);
      chk("t4_hold_s", {16'b0, S}, 32'h2345);
      step();
    end
    Out_ready = 1'b1;
    chk("t4_first", {16'b0, S}, 32'h2345);
    step();
    chk("t4_second_v", {31'b0, Out_valid}, 32'd1);
    chk("t4_second", {16'b0, S}, 32'hBCDF);
    step();
    chk("t4_empty", {31'b0, Out_valid}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      A = 16'(16'h0100 + i);
      B = 16'h0A0A;
      Cin = 1'b0;
      In_valid = 1'b1;
      step();
    end
    Rst_n = 1'b0;
    In_valid = 1'b0;
    #1;
    chk("t5_valid", {31'b0, Out_valid}, 32'd0);
    chk("t5_sum", {16'b0, S}, 32'd0);
    step();
    Rst_n = 1'b1;
    pin("t5_post", 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0);
    step();

`ifdef CLA_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    step();
    chk("t6a_sum", {16'b0, S}, 32'h8000);
    chk("t6a_ovf", {31'b0, Ovf}, 32'd1);
    chk("t6a_cout", {31'b0, Cout}, 32'd0);
    send(16'h8000, 16'h8000, 1'b0);
    step();
    chk("t6b_sum", {16'b0, S}, 32'h0000);
    chk("t6b_ovf", {31'b0, Ovf}, 32'd1);
    chk("t6b_cout", {31'b0, Cout}, 32'd1);
    send(16'h0003, 16'h0004, 1'b0);
    step();
    chk("t6c_ovf", {31'b0, Ovf}, 32'd0);
    step();
`endif

    repeat (4) step();
    chk("drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
